jpegls_ctx_model: RTL and testbench

Context-modelling and prediction stage placed directly after the neighbourhood/gradient extractor in the JPEG-LS (LOCO-I) encoder path. Per valid pixel it quantises the three local gradients into a folded context index and sign, forms the median-edge-detector (MED) prediction and the signed prediction residual, and detects and counts runs of identical pixels. Its output beats feed the downstream residual coder.

---
 rtl/jpegls_ctx_model.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_jpegls_ctx_model.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpegls_ctx_model.sv
// JPEG-LS context model: gradient quantisation/fold, MED prediction, residual, run detection.
// Latency: in_en at cycle n gives its beat (if any) at cycle n+3; full-rate, three register stages.
// No backpressure: no stall input, one output beat per pixel at most. Run mode under `JPEGLS_RUN_MODE_EN.
module jpegls_ctx_model #(
    parameter int IMAGE_W = 256,
    parameter int T1      = 3,
    parameter int T2      = 7,
    parameter int T3      = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_en,
    input  logic [15:0] Rx,
    input  logic [15:0] Ra,
    input  logic [15:0] Rb,
    input  logic [15:0] Rc,
    input  logic [15:0] Rd,
    input  logic [15:0] D1,
    input  logic [15:0] D2,
    input  logic [15:0] D3,
    output logic        out_valid,
    output logic        out_run,
    output logic [9:0]  run_len,
    output logic        out_eol,
    output logic [8:0]  ctx_idx,
    output logic        ctx_sign,
    output logic [15:0] pred,
    output logic [16:0] errval
);

    localparam logic [9:0]         L_LAST = 10'(IMAGE_W - 1);
    localparam logic signed [16:0] L_T1   = 17'(T1);
    localparam logic signed [16:0] L_T2   = 17'(T2);
    localparam logic signed [16:0] L_T3   = 17'(T3);
    localparam logic signed [16:0] L_NT1  = 17'(-T1);
    localparam logic signed [16:0] L_NT2  = 17'(-T2);
    localparam logic signed [16:0] L_NT3  = 17'(-T3);

    // Rd only shapes the precomputed gradients; it is not needed here.
    logic w_unused_rd;
    assign w_unused_rd = ^Rd;

    function automatic logic signed [3:0] f_quant(input logic [15:0] d);
        logic signed [16:0] x;
        x = {d[15], d};
        if (x <= L_NT3)       f_quant = -4'sd4;
        else if (x <= L_NT2)  f_quant = -4'sd3;
        else if (x <= L_NT1)  f_quant = -4'sd2;
        else if (x[16])       f_quant = -4'sd1;
        else if (x == '0)     f_quant = 4'sd0;
        else if (x < L_T1)    f_quant = 4'sd1;
        else if (x < L_T2)    f_quant = 4'sd2;
        else if (x < L_T3)    f_quant = 4'sd3;
        else                  f_quant = 4'sd4;
    endfunction

    // ---------------- column counter ----------------
    logic [9:0] r_col;
    logic       w_eol;
    assign w_eol = (r_col == L_LAST);

    // Column position; wraps at the last pixel of each line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_col <= '0;
        else if (in_en) r_col <= w_eol ? 10'd0 : r_col + 10'd1;
    end

    // ---------------- stage 1: quantise + MED ----------------
    logic [15:0] w_min, w_max, w_med;
    assign w_min = (Ra < Rb) ? Ra : Rb;
    assign w_max = (Ra < Rb) ? Rb : Ra;
    // Ra+Rb-Rc lies between min and max here, so 16-bit arithmetic cannot overflow.
    assign w_med = (Rc >= w_max) ? w_min : (Rc <= w_min) ? w_max : (Ra + Rb - Rc);

    logic              r1_vld, r1_eol;
    logic signed [3:0] r1_q1, r1_q2, r1_q3;
    logic [15:0]       r1_rx, r1_med;
`ifdef JPEGLS_RUN_MODE_EN
    logic [15:0]       r1_ra, r1_px_int;
    logic              r1_rx_eq_ra;
`endif

    // Capture quantised gradients, MED prediction and pixel flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_vld <= 1'b0;  r1_eol <= 1'b0;
            r1_q1  <= '0;    r1_q2  <= '0;   r1_q3 <= '0;
            r1_rx  <= '0;    r1_med <= '0;
`ifdef JPEGLS_RUN_MODE_EN
            r1_ra  <= '0;    r1_px_int <= '0;  r1_rx_eq_ra <= 1'b0;
`endif
        end else begin
            r1_vld <= in_en;
            if (in_en) begin
                r1_eol <= w_eol;
                r1_q1  <= f_quant(D1);
                r1_q2  <= f_quant(D2);
                r1_q3  <= f_quant(D3);
                r1_rx  <= Rx;
                r1_med <= w_med;
`ifdef JPEGLS_RUN_MODE_EN
                r1_ra       <= Ra;
                r1_px_int   <= (Ra == Rb) ? Ra : Rb;
                r1_rx_eq_ra <= (Rx == Ra);
`endif
            end
        end
    end

    // ---------------- stage 2: fold, index, residual ----------------
    logic              w_neg;
    logic signed [3:0] w_f1, w_f2, w_f3;
    logic [8:0]        w_idx;
    logic [16:0]       w_diff;
    assign w_neg  = r1_q1[3] | ((r1_q1 == 4'sd0) & r1_q2[3])
                  | ((r1_q1 == 4'sd0) & (r1_q2 == 4'sd0) & r1_q3[3]);
    assign w_f1   = w_neg ? -r1_q1 : r1_q1;
    assign w_f2   = w_neg ? -r1_q2 : r1_q2;
    assign w_f3   = w_neg ? -r1_q3 : r1_q3;
    // Folded index is always 0..364, so modulo-512 arithmetic gives the exact value.
    assign w_idx  = 9'd81 * {{5{w_f1[3]}}, w_f1} + 9'd9 * {{5{w_f2[3]}}, w_f2}
                  + {{5{w_f3[3]}}, w_f3};
    assign w_diff = {1'b0, r1_rx} - {1'b0, r1_med};

    logic        r2_vld, r2_eol, r2_sign;
    logic [8:0]  r2_idx;
    logic [15:0] r2_pred;
    logic [16:0] r2_err;
`ifdef JPEGLS_RUN_MODE_EN
    logic        r2_zero, r2_rx_eq_ra;
    logic [15:0] r2_ra, r2_px_int;
    logic [16:0] r2_err_int;
`endif

    // Register folded context, regular residual and run-interruption terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_vld  <= 1'b0;  r2_eol <= 1'b0;  r2_sign <= 1'b0;
            r2_idx  <= '0;    r2_pred <= '0;   r2_err <= '0;
`ifdef JPEGLS_RUN_MODE_EN
            r2_zero <= 1'b0;  r2_rx_eq_ra <= 1'b0;
            r2_ra   <= '0;    r2_px_int <= '0;  r2_err_int <= '0;
`endif
        end else begin
            r2_vld <= r1_vld;
            if (r1_vld) begin
                r2_eol  <= r1_eol;
                r2_sign <= w_neg;
                r2_idx  <= w_idx;
                r2_pred <= r1_med;
                r2_err  <= w_neg ? -w_diff : w_diff;
`ifdef JPEGLS_RUN_MODE_EN
                r2_zero     <= (r1_q1 == 4'sd0) && (r1_q2 == 4'sd0) && (r1_q3 == 4'sd0);
                r2_rx_eq_ra <= r1_rx_eq_ra;
                r2_ra       <= r1_ra;
                r2_px_int   <= r1_px_int;
                r2_err_int  <= {1'b0, r1_rx} - {1'b0, r1_px_int};
`endif
            end
        end
    end

    // ---------------- stage 3: run FSM + output register ----------------
    logic        w_beat, w_b_sign;
    logic [8:0]  w_b_idx;
    logic [15:0] w_b_pred;
    logic [16:0] w_b_err;

`ifdef JPEGLS_RUN_MODE_EN
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
    state_t     r_state, w_state_nxt;
    logic [9:0] r_run_cnt, w_cnt_nxt, w_b_len;
    logic       w_b_run;

    // Run state and length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_cnt_nxt;
        end
    end

    // Next run state and beat contents; an idle flat pixel behaves like a zero-length run.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_run_cnt;
        w_beat      = 1'b0;
        w_b_run     = 1'b0;
        w_b_len     = '0;
        w_b_idx     = r2_idx;
        w_b_sign    = r2_sign;
        w_b_pred    = r2_pred;
        w_b_err     = r2_err;
        if (r2_vld) begin
            if ((r_state == ST_RUN) || r2_zero) begin
                w_b_run  = 1'b1;
                w_b_idx  = '0;
                w_b_sign = 1'b0;
                if (r2_rx_eq_ra) begin
                    w_b_len  = ((r_state == ST_RUN) ? r_run_cnt : 10'd0) + 10'd1;
                    w_b_pred = r2_ra;
                    w_b_err  = '0;
                    if (r2_eol) begin
                        w_beat      = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = w_b_len;
                    end
                end else begin
                    w_beat      = 1'b1;
                    w_b_len     = (r_state == ST_RUN) ? r_run_cnt : 10'd0;
                    w_b_pred    = r2_px_int;
                    w_b_err     = r2_err_int;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end else begin
                w_beat = 1'b1;
            end
        end
    end

    logic       r_out_run;
    logic [9:0] r_run_len;

    // Run-specific output fields, held between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_run <= 1'b0;
            r_run_len <= '0;
        end else if (w_beat) begin
            r_out_run <= w_b_run;
            r_run_len <= w_b_len;
        end
    end
    assign out_run = r_out_run;
    assign run_len = r_run_len;
`else
    // Every valid pixel is a regular beat.
    always_comb begin
        w_beat   = r2_vld;
        w_b_idx  = r2_idx;
        w_b_sign = r2_sign;
        w_b_pred = r2_pred;
        w_b_err  = r2_err;
    end
    assign out_run = 1'b0;
    assign run_len = '0;
`endif

    logic        r_out_valid, r_out_eol, r_ctx_sign;
    logic [8:0]  r_ctx_idx;
    logic [15:0] r_pred;
    logic [16:0] r_errval;

    // Output register: valid pulses one cycle per beat, data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;  r_out_eol <= 1'b0;  r_ctx_sign <= 1'b0;
            r_ctx_idx   <= '0;    r_pred    <= '0;    r_errval   <= '0;
        end else begin
            r_out_valid <= w_beat;
            if (w_beat) begin
                r_out_eol  <= r2_eol;
                r_ctx_idx  <= w_b_idx;
                r_ctx_sign <= w_b_sign;
                r_pred     <= w_b_pred;
                r_errval   <= w_b_err;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_eol   = r_out_eol;
    assign ctx_idx   = r_ctx_idx;
    assign ctx_sign  = r_ctx_sign;
    assign pred      = r_pred;
    assign errval    = r_errval;

endmodule

// File: tb/tb_jpegls_ctx_model.sv
// Bench for jpegls_ctx_model: directed scenarios plus random pixels against a reference model.
// Expected beats are delayed three cycles in a queue; all outputs are compared every cycle.
// Adapts its expectations to whether JPEGLS_RUN_MODE_EN is defined.
module tb_jpegls_ctx_model;

    localparam int W  = 8;
    localparam int T1 = 3;
    localparam int T2 = 7;
    localparam int T3 = 21;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_en = 1'b0;
    logic [15:0] Rx = '0, Ra = '0, Rb = '0, Rc = '0, Rd = '0, D1 = '0, D2 = '0, D3 = '0;
    logic        out_valid, out_run, out_eol, ctx_sign;
    logic [9:0]  run_len;
    logic [8:0]  ctx_idx;
    logic [15:0] pred;
    logic [16:0] errval;

    jpegls_ctx_model #(.IMAGE_W(W), .T1(T1), .T2(T2), .T3(T3)) dut (
        .clk(clk), .rst_n(rst_n), .in_en(in_en),
        .Rx(Rx), .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rd(Rd),
        .D1(D1), .D2(D2), .D3(D3),
        .out_valid(out_valid), .out_run(out_run), .run_len(run_len), .out_eol(out_eol),
        .ctx_idx(ctx_idx), .ctx_sign(ctx_sign), .pred(pred), .errval(errval)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vld; bit run; int len; bit eol; int idx; bit sgn; int pred; int err;
    } beat_t;

    int    checks = 0;
    int    failures = 0;
    int    m_col, m_cnt;
    bit    m_in_run;
    beat_t m_hold;
    beat_t exp_q[$];
    int    n_beats, n_eol;
    logic        l_run, l_eol, l_sgn;
    logic [9:0]  l_len;
    logic [8:0]  l_idx;
    logic [15:0] l_pred;
    logic [16:0] l_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int quant(input int d);
        if (d <= -T3) return -4;
        if (d <= -T2) return -3;
        if (d <= -T1) return -2;
        if (d < 0)    return -1;
        if (d == 0)   return 0;
        if (d < T1)   return 1;
        if (d < T2)   return 2;
        if (d < T3)   return 3;
        return 4;
    endfunction

    function automatic int med(input int a, input int b, input int c);
        int mx, mn;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        if (c >= mx) return mn;
        if (c <= mn) return mx;
        return a + b - c;
    endfunction

    function automatic logic [55:0] pack(input beat_t b);
        logic [9:0]  len;
        logic [8:0]  idx;
        logic [15:0] p;
        logic [16:0] e;
        len = b.len[9:0]; idx = b.idx[8:0]; p = b.pred[15:0]; e = b.err[16:0];
        return {b.vld, b.run, len, b.eol, idx, b.sgn, p, e};
    endfunction

    // Reference behaviour of one accepted pixel.
    task automatic model_pixel(input int rx, input int ra, input int rb, input int rc,
                               input int d1, input int d2, input int d3, output beat_t b);
        int q1, q2, q3, px, prior;
        bit neg, eol;
        b   = '{default: 0};
        eol = (m_col == W - 1);
        m_col = eol ? 0 : m_col + 1;
        q1 = quant(d1); q2 = quant(d2); q3 = quant(d3);
        neg = (q1 < 0) || (q1 == 0 && q2 < 0) || (q1 == 0 && q2 == 0 && q3 < 0);
        if (neg) begin q1 = -q1; q2 = -q2; q3 = -q3; end
        px = med(ra, rb, rc);
        b.vld = 1; b.eol = eol; b.idx = 81 * q1 + 9 * q2 + q3; b.sgn = neg;
        b.pred = px; b.err = neg ? px - rx : rx - px;
`ifdef JPEGLS_RUN_MODE_EN
        if (m_in_run || (q1 == 0 && q2 == 0 && q3 == 0)) begin
            prior = m_in_run ? m_cnt : 0;
            b.run = 1; b.idx = 0; b.sgn = 0;
            if (rx == ra) begin
                if (eol) begin
                    b.len = prior + 1; b.pred = ra; b.err = 0;
                    m_in_run = 0; m_cnt = 0;
                end else begin
                    b.vld = 0; m_in_run = 1; m_cnt = prior + 1;
                end
            end else begin
                b.len = prior;
                b.pred = (ra == rb) ? ra : rb;
                b.err = rx - b.pred;
                m_in_run = 0; m_cnt = 0;
            end
        end
`else
        prior = 0;
`endif
    endtask

    task automatic cycle(input bit en, input int rx, input int ra, input int rb, input int rc,
                         input int d1, input int d2, input int d3);
        beat_t b, e;
        b = '{default: 0};
        @(negedge clk);
        in_en = en;
        Rx = 16'(rx); Ra = 16'(ra); Rb = 16'(rb); Rc = 16'(rc); Rd = 16'(rb);
        D1 = 16'(d1); D2 = 16'(d2); D3 = 16'(d3);
        if (en) model_pixel(rx, ra, rb, rc, d1, d2, d3, b);
        if (b.vld) m_hold = b;
        else       m_hold.vld = 0;
        exp_q.push_back(m_hold);
        @(posedge clk);
        #1;
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            chk("beat", {8'd0, out_valid, out_run, run_len, out_eol, ctx_idx, ctx_sign, pred, errval},
                {8'd0, pack(e)});
        end
        if (out_valid) begin
            n_beats++;
            if (out_eol) n_eol++;
            l_run = out_run; l_len = run_len; l_eol = out_eol; l_idx = ctx_idx;
            l_sgn = ctx_sign; l_pred = pred; l_err = errval;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flat_pixel(input int v);
        cycle(1, v, v, v, v, 0, 0, 0);
    endtask

    task automatic do_reset();
        beat_t z;
        z = '{default: 0};
        @(negedge clk);
        rst_n = 1'b0;
        in_en = 1'b0;
        #1;
        chk("reset_outputs", {8'd0, out_valid, out_run, run_len, out_eol, ctx_idx, ctx_sign, pred, errval},
            64'd0);
        m_col = 0; m_cnt = 0; m_in_run = 0; m_hold = z;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
        n_beats = 0; n_eol = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int rand_d();
        int m;
        case ($urandom_range(3))
            0: return 0;
            1: return int'($urandom_range(50)) - 25;
            2: return int'($signed(16'($urandom())));
            default: begin
                case ($urandom_range(5))
                    0: m = T1 - 1;
                    1: m = T1;
                    2: m = T2 - 1;
                    3: m = T2;
                    4: m = T3 - 1;
                    default: m = T3;
                endcase
                return ($urandom_range(1) != 0) ? m : -m;
            end
        endcase
    endfunction

    initial begin
        int rx, ra, rb, rc, d1, d2, d3;
        bit en;

        // Flat line of 8 identical pixels.
        do_reset();
        for (int i = 0; i < W; i++) flat_pixel(100);
        idle(3);
`ifdef JPEGLS_RUN_MODE_EN
        chk("flat_beats", n_beats, 1);
        chk("flat_run", l_run, 1);
        chk("flat_len", l_len, 8);
`else
        chk("flat_beats", n_beats, 8);
        chk("flat_eol_count", n_eol, 1);
        chk("flat_run", l_run, 0);
        chk("flat_idx", l_idx, 0);
`endif
        chk("flat_eol", l_eol, 1);
        chk("flat_err", l_err, 0);
        chk("flat_pred", l_pred, 100);

        // Regular pixel.
        do_reset();
        cycle(1, 25, 10, 20, 5, 3, 15, -5);
        idle(3);
        chk("reg_beats", n_beats, 1);
        chk("reg_pred", l_pred, 20);
        chk("reg_idx", l_idx, 187);
        chk("reg_sign", l_sgn, 0);
        chk("reg_err", l_err, 5);
        chk("reg_run", l_run, 0);

        // Sign-folded context.
        do_reset();
        cycle(1, 48, 50, 50, 50, -3, 0, 0);
        idle(3);
        chk("fold_sign", l_sgn, 1);
        chk("fold_idx", l_idx, 162);
        chk("fold_pred", l_pred, 50);
        chk("fold_err", l_err, 2);

        // Run interrupted after three pixels.
        do_reset();
        for (int i = 0; i < 3; i++) flat_pixel(7);
        cycle(1, 9, 7, 7, 7, 0, 0, 0);
        idle(3);
`ifdef JPEGLS_RUN_MODE_EN
        chk("intr_beats", n_beats, 1);
        chk("intr_run", l_run, 1);
        chk("intr_len", l_len, 3);
`else
        chk("intr_beats", n_beats, 4);
`endif
        chk("intr_pred", l_pred, 7);
        chk("intr_err", l_err, 2);
        chk("intr_eol", l_eol, 0);

        // Reset in the middle of a run, then a fresh flat line.
        do_reset();
        flat_pixel(100);
        flat_pixel(100);
        do_reset();
        idle(3);
        chk("midrun_no_beat", n_beats, 0);
        for (int i = 0; i < W; i++) flat_pixel(100);
        idle(3);
`ifdef JPEGLS_RUN_MODE_EN
        chk("midrun_len", l_len, 8);
        chk("midrun_beats", n_beats, 1);
`else
        chk("midrun_beats", n_beats, 8);
`endif
        chk("midrun_eol", l_eol, 1);

        // Randomised pixels, biased towards runs and threshold boundaries.
        do_reset();
        for (int it = 0; it < 800; it++) begin
            if (it == 400) do_reset();
            en = ($urandom_range(9) != 0);
            ra = ($urandom_range(3) == 0) ? int'($urandom_range(32767)) : 100 + int'($urandom_range(20));
            if ($urandom_range(1) != 0)      rx = ra;
            else if ($urandom_range(3) == 0) rx = int'($urandom_range(32767));
            else                             rx = ra + int'($urandom_range(4)) - 2;
            if (rx > 32767) rx = 32767;
            rb = ($urandom_range(1) != 0) ? ra : int'($urandom_range(32767));
            rc = ($urandom_range(2) == 0) ? ra : int'($urandom_range(32767));
            if ($urandom_range(1) != 0) begin
                d1 = 0; d2 = 0; d3 = 0;
            end else begin
                d1 = rand_d(); d2 = rand_d(); d3 = rand_d();
            end
            cycle(en, rx, ra, rb, rc, d1, d2, d3);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
